// File: rtl/button_pkg.sv
// button_pkg: shared constants and arbiter state encoding for the button event arbiter.
package button_pkg;
  localparam logic EV_RELEASE = 1'b0;
  localparam logic EV_PRESS = 1'b1;
  localparam int DEF_TICK_DIV = 2500;
  localparam int DEF_STABLE_SAMPLES = 4;
  typedef enum logic {IDLE, OFFER} arb_state_e;
endpackage

// File: rtl/button_filter.sv
// button_filter: per-button synchroniser, tick-sampled stability counter and pending event slot.
module button_filter
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  input  logic clear,
  output logic state,
  output logic pending,
  output logic dir,
  output logic ovf_set
);
  localparam int CW = $clog2(STABLE_SAMPLES);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic state_q, state_d, pending_q, pending_d, dir_q, dir_d, edge_det;
  always_comb begin
    sync_d = {sync_q[0], raw};
    edge_det = tick && (sync_q[1] != state_q) && (cnt_q == CW'(STABLE_SAMPLES - 1));
    cnt_d = !tick ? cnt_q : (sync_q[1] == state_q || edge_det) ? '0 : cnt_q + 1'b1;
    state_d = edge_det ? sync_q[1] : state_q;
    dir_d = edge_det ? sync_q[1] : dir_q;
    // A new edge beats a same-cycle grant clear, and only counts as overflow if not being granted
    pending_d = edge_det ? 1'b1 : clear ? 1'b0 : pending_q;
    ovf_set = edge_det && pending_q && !clear;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      state_q <= 1'b0;
      pending_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      pending_q <= pending_d;
      dir_q <= dir_d;
    end
  end
  assign state = state_q;
  assign pending = pending_q;
  assign dir = dir_q;
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces N buttons on a shared sample tick and serialises
// press/release events round-robin onto one valid/ready port.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int N_BUTTONS = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         button,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [$clog2(N_BUTTONS)-1:0] event_id,
  output logic                         event_press,
  output logic [N_BUTTONS-1:0]         button_state,
  output logic                         overflow
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_BUTTONS);
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  logic [N_BUTTONS-1:0] pending, dir, ovf_set, clear;
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, sel, idx;
  logic valid_q, valid_d, press_q, press_d, overflow_q, overflow_d, found;
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_filt
    button_filter #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_filter (
      .clk(clk), .reset(reset), .raw(button[g]), .tick(tick), .clear(clear[g]),
      .state(button_state[g]), .pending(pending[g]), .dir(dir[g]), .ovf_set(ovf_set[g])
    );
  end
  always_comb begin
    tick = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
    overflow_d = overflow_q | (|ovf_set);
    found = 1'b0;
    sel = '0;
    idx = '0;
    // Scan downward so the closest pending index at or above rr_ptr is the one kept
    for (int k = N_BUTTONS - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % N_BUTTONS);
      if (pending[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    state_d = state_q;
    valid_d = valid_q;
    id_d = id_q;
    press_d = press_q;
    rr_ptr_d = rr_ptr_q;
    clear = '0;
    if (state_q == IDLE && found) begin
      clear[sel] = 1'b1;
      id_d = sel;
      press_d = dir[sel];
      valid_d = 1'b1;
      state_d = OFFER;
    end else if (state_q == OFFER && event_ready) begin
      valid_d = 1'b0;
      rr_ptr_d = (id_q == IW'(N_BUTTONS - 1)) ? '0 : id_q + 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      press_q <= 1'b0;
      valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      press_q <= press_d;
      valid_q <= valid_d;
      overflow_q <= overflow_d;
    end
  end
  assign event_valid = valid_q;
  assign event_id = id_q;
  assign event_press = press_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: scenario tasks with a scoreboard of expected events popped on each handshake.
module tb_button_event_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic press;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] button = '0;
  logic event_valid, event_ready = 1'b1, event_press, overflow;
  logic [1:0] event_id;
  logic [3:0] button_state;
  ev_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  button_event_arbiter #(.N_BUTTONS(4), .TICK_DIV(4), .STABLE_SAMPLES(3)) dut (
    .clk(clk), .reset(reset), .button(button), .event_valid(event_valid),
    .event_ready(event_ready), .event_id(event_id), .event_press(event_press),
    .button_state(button_state), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] id, input logic press);
    ev_t e;
    e.id = id;
    e.press = press;
    sb.push_back(e);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    sb.delete();
  endtask
  task automatic expect_events(input int n, input int budget, input string name);
    int got = 0;
    ev_t e;
    for (int c = 0; c < budget && got < n; c++) begin
      if (event_valid && event_ready) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL %s unexpected event id=%0d press=%0d", name, event_id, event_press);
        end else begin
          e = sb.pop_front();
          if ({event_id, event_press} !== {e.id, e.press})
            $display("FAIL %s event got id=%0d press=%0d expected id=%0d press=%0d",
                     name, event_id, event_press, e.id, e.press);
          else pass_cnt++;
        end
        got++;
      end
      cyc();
    end
    total_cnt++;
    if (got !== n) $display("FAIL %s event count got=%0d expected=%0d", name, got, n);
    else pass_cnt++;
  endtask
  task automatic wait_valid(input int budget, input string name);
    int c = 0;
    while (!event_valid && c < budget) begin
      cyc();
      c++;
    end
    total_cnt++;
    if (event_valid !== 1'b1) $display("FAIL %s wait event_valid got=%b expected=1", name, event_valid);
    else pass_cnt++;
  endtask
  task automatic expect_quiet(input int cycles, input string name);
    int bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (event_valid !== 1'b0) bad++;
      cyc();
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL %s quiet: event_valid high cycles=%0d expected=0", name, bad);
    else pass_cnt++;
  endtask
  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({event_valid, event_id, event_press, button_state, overflow} !== 9'b0)
      $display("FAIL reset outputs got valid=%b id=%0d press=%b state=%b ovf=%b expected all 0",
               event_valid, event_id, event_press, button_state, overflow);
    else pass_cnt++;
  endtask
  task automatic test_bounce_hold();
    button[0] = 1'b1;
    cyc(5);
    button[0] = 1'b0;
    cyc(5);
    button[0] = 1'b1;
    total_cnt++;
    if ({event_valid, button_state} !== 5'b0)
      $display("FAIL bounce early valid=%b state=%b expected 0/0000", event_valid, button_state);
    else pass_cnt++;
    push(2'd0, 1'b1);
    expect_events(1, 40, "bounce_hold");
    total_cnt++;
    if (button_state !== 4'b0001) $display("FAIL bounce state got=%b expected=0001", button_state);
    else pass_cnt++;
  endtask
  task automatic test_backpressure();
    int bad = 0;
    event_ready = 1'b0;
    button[1] = 1'b1;
    push(2'd1, 1'b1);
    wait_valid(40, "backpressure");
    for (int c = 0; c < 100; c++) begin
      if ({event_valid, event_id, event_press} !== 4'b1011) bad++;
      cyc();
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL backpressure hold unstable cycles got=%0d expected=0", bad);
    else pass_cnt++;
    event_ready = 1'b1;
    expect_events(1, 2, "backpressure");
    event_ready = 1'b0;
    total_cnt++;
    if (event_valid !== 1'b0) $display("FAIL backpressure post-accept valid got=%b expected=0", event_valid);
    else pass_cnt++;
    expect_quiet(20, "backpressure_single");
    event_ready = 1'b1;
    button[1:0] = 2'b00;
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    expect_events(2, 60, "release_rr");
  endtask
  task automatic test_fairness();
    do_reset();
    button = 4'b1010;
    push(2'd1, 1'b1);
    push(2'd3, 1'b1);
    expect_events(2, 60, "fair_press");
    button = 4'b0000;
    push(2'd1, 1'b0);
    push(2'd3, 1'b0);
    expect_events(2, 60, "fair_release");
    expect_quiet(10, "fair_extra");
  endtask
  task automatic test_overflow();
    int c = 0;
    do_reset();
    event_ready = 1'b0;
    button[0] = 1'b1;
    push(2'd0, 1'b1);
    wait_valid(40, "overflow");
    button[2] = 1'b1;
    while (button_state[2] !== 1'b1 && c < 40) begin
      cyc();
      c++;
    end
    button[2] = 1'b0;
    c = 0;
    while (button_state[2] !== 1'b0 && c < 40) begin
      cyc();
      c++;
    end
    cyc();
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow flag got=%b expected=1", overflow);
    else pass_cnt++;
    push(2'd2, 1'b0);
    event_ready = 1'b1;
    expect_events(2, 20, "overflow");
    expect_quiet(20, "overflow_single");
    button[0] = 1'b0;
    push(2'd0, 1'b0);
    expect_events(1, 40, "overflow_release");
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow sticky got=%b expected=1", overflow);
    else pass_cnt++;
  endtask
  task automatic test_glitch();
    do_reset();
    button[3] = 1'b1;
    cyc(8);
    button[3] = 1'b0;
    expect_quiet(30, "glitch");
    total_cnt++;
    if ({button_state[3], overflow} !== 2'b00)
      $display("FAIL glitch state3=%b ovf=%b expected 0/0", button_state[3], overflow);
    else pass_cnt++;
  endtask
  task automatic test_reset_mid_offer();
    event_ready = 1'b0;
    button[0] = 1'b1;
    wait_valid(40, "midreset");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    total_cnt++;
    if ({event_valid, button_state, overflow} !== 6'b0)
      $display("FAIL midreset got valid=%b state=%b ovf=%b expected 0/0000/0",
               event_valid, button_state, overflow);
    else pass_cnt++;
    push(2'd0, 1'b1);
    event_ready = 1'b1;
    expect_events(1, 40, "midreset_repress");
  endtask
  initial begin
    test_reset();
    test_bounce_hold();
    test_backpressure();
    test_fairness();
    test_overflow();
    test_glitch();
    test_reset_mid_offer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
